mc_fifo_ctrl: RTL
=================

Name: mc_fifo_ctrl

Overview:
Parametrised multi-channel FIFO: the successor to the two-bank per-level buffer used between merge-tree stages. One shared RAM is partitioned into 2^C_LOG independent circular channels. Adds over the previous generation:
- per-channel occupancy counters
- programmable almost-full flags for upstream back-pressure
- per-channel flush
- a registered read port with valid/index tagging

Sits between a sorter stage and the next tree level, one instance per level.

Parameters:
C_LOG, 2, number of channels in log2 (must be ≥1)
FIFO_SIZE, 3, depth per channel in log2 (must be ≥1)
FIFO_WIDTH, 64, data width in bits
AF_THRESH, 6, almost-full asserts when channel count ≥ AF_THRESH (1..2^FIFO_SIZE)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous assert, active low
ENQ  in  1  write request
ENQ_IDX  in  C_LOG  write channel
DIN  in  FIFO_WIDTH  write data
DEQ  in  1  read request
DEQ_IDX  in  C_LOG  read channel
FLUSH  in  1  flush request
FLUSH_IDX  in  C_LOG  channel to flush
CNT_IDX  in  C_LOG  channel whose count is reported on CNT
DOT  out  FIFO_WIDTH  read data, registered
DOT_VLD  out  1  DOT holds data from an accepted read
DOT_IDX  out  C_LOG  channel DOT came from
EMP  out  2^C_LOG  per-channel empty
FULL  out  2^C_LOG  per-channel full
AFULL  out  2^C_LOG  per-channel almost-full
CNT  out  FIFO_SIZE+1  occupancy of channel CNT_IDX, combinational from state
ERR  out  2  sticky error flags; present only with MCF_ERR_EN

Behaviour:
Reset (async, while RST_N=0):
- all head/tail pointers = 0; all counts = 0
- EMP all 1; FULL and AFULL all 0
- DOT_VLD = 0, DOT_IDX = 0, DOT = 0
- ERR = 0
- RAM contents are not reset

State and flags:
- Per channel c: head, tail (FIFO_SIZE bits each, wrap modulo 2^FIFO_SIZE) and cnt (FIFO_SIZE+1 bits).
- EMP[c] = (cnt==0); FULL[c] = (cnt==2^FIFO_SIZE); AFULL[c] = (cnt≥AF_THRESH). All are decoded directly from registered state, with no combinational path from the request inputs.

Write:
- Accepted iff ENQ=1 and FULL[ENQ_IDX]=0, with one exception: if DEQ is also accepted on the same channel in the same cycle, a write to a full channel is accepted.
- On accept: RAM[{ENQ_IDX, tail}] ← DIN, tail+1.

Read:
- Accepted iff DEQ=1 and EMP[DEQ_IDX]=0. An empty channel has no bypass; a simultaneous write to that channel does not make a read accepted.
- On accept: DOT ← RAM[{DEQ_IDX, head}] on the same edge, head+1, DOT_VLD←1, DOT_IDX←DEQ_IDX. Latency is 1 cycle.
- Cycle with no accepted read: DOT_VLD←0, and DOT and DOT_IDX hold their values.

Count update per channel: +1 on an accepted write only, −1 on an accepted read only, unchanged when both are accepted on the same channel. Writes and reads on different channels update independently.

Flush:
- FLUSH=1 sets head=tail=cnt=0 for FLUSH_IDX on the next edge.
- Flush has priority over a write or read to the same channel in that cycle: the write is dropped, and the read is dropped with DOT_VLD=0.
- Other channels are unaffected.

Ignored requests (write to a full channel, read from an empty channel) change no state.

Reset mid-operation: all state clears immediately on RST_N falling. An in-flight DOT_VLD drops asynchronously.

Optional Feature:
Macro MCF_ERR_EN.
- Defined:
  - ERR[0] sets sticky on any cycle with ENQ=1 to a full channel that is not rescued by a same-channel accepted read.
  - ERR[1] sets sticky on DEQ=1 to an empty channel.
  - Both bits clear only on reset.
  - A request dropped because of a flush is not flagged.
- Undefined: port ERR and its logic are absent; illegal requests are silently ignored as described above.

Test Plan:
1. Reset, C_LOG=2, FIFO_SIZE=3: enqueue 0xA0..0xA7 to ch1 → FULL[1]=1 after the 8th write, AFULL[1]=1 after the 6th, CNT(CNT_IDX=1)=8. 9th write dropped, CNT stays 8; with MCF_ERR_EN, ERR=2'b01.
2. Drain ch1 with 8 back-to-back DEQ → DOT=0xA0..0xA7 each one cycle after its DEQ, DOT_VLD=1 for 8 cycles, DOT_IDX=1, EMP[1]=1 at the end. An extra DEQ gives DOT_VLD=0; with MCF_ERR_EN, ERR[1]=1.
3. Interleave: ENQ ch0 0x10 while DEQ ch3 (holding 0x33) in the same cycle → DOT=0x33, DOT_IDX=3, CNT ch0=1, CNT ch3 decrements. Wrap test: 20 enq/deq pairs on ch2 → data order preserved across the pointer wrap.
4. Full ch0 with simultaneous ENQ 0x55 and DEQ on ch0 → both accepted, CNT stays 8, DOT = oldest entry, 0x55 read out last.
5. Ch2 holding 3 entries: FLUSH ch2 together with ENQ and DEQ on ch2 → next cycle CNT ch2=0, EMP[2]=1, DOT_VLD=0, no ERR. Other channels' counts unchanged.
6. Assert RST_N=0 asynchronously mid-stream with DOT_VLD=1 → DOT_VLD, counts, FULL and AFULL go to 0 before the next CLK edge; EMP all 1.

Source files
------------

// File: rtl/mc_fifo_ctrl.sv
// rtl/mc_fifo_ctrl.sv - multi-channel circular FIFO over one shared RAM, registered read port
// Sticky request-error flags on port ERR exist only when MCF_ERR_EN is defined.
module mc_fifo_ctrl #(
  parameter int C_LOG      = 2,
  parameter int FIFO_SIZE  = 3,
  parameter int FIFO_WIDTH = 64,
  parameter int AF_THRESH  = 6
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ENQ,
  input  logic [C_LOG-1:0]         ENQ_IDX,
  input  logic [FIFO_WIDTH-1:0]    DIN,
  input  logic                     DEQ,
  input  logic [C_LOG-1:0]         DEQ_IDX,
  input  logic                     FLUSH,
  input  logic [C_LOG-1:0]         FLUSH_IDX,
  input  logic [C_LOG-1:0]         CNT_IDX,
  output logic [FIFO_WIDTH-1:0]    DOT,
  output logic                     DOT_VLD,
  output logic [C_LOG-1:0]         DOT_IDX,
  output logic [(1<<C_LOG)-1:0]    EMP,
  output logic [(1<<C_LOG)-1:0]    FULL,
  output logic [(1<<C_LOG)-1:0]    AFULL,
  output logic [FIFO_SIZE:0]       CNT
`ifdef MCF_ERR_EN
  ,
  output logic [1:0]               ERR
`endif
);

  localparam int NCH   = 1 << C_LOG;
  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam int AW    = C_LOG + FIFO_SIZE;
  localparam logic [FIFO_SIZE:0] CNT_FULL = (FIFO_SIZE+1)'(DEPTH);
  localparam logic [FIFO_SIZE:0] CNT_AF   = (FIFO_SIZE+1)'(AF_THRESH);

  logic [FIFO_WIDTH-1:0] ram  [NCH*DEPTH];
  logic [FIFO_SIZE-1:0]  head [NCH];
  logic [FIFO_SIZE-1:0]  tail [NCH];
  logic [FIFO_SIZE:0]    cnt  [NCH];

  logic           flush_enq;
  logic           flush_deq;
  logic           rd_ok;
  logic           wr_ok;
  logic           wr_rescue;
  logic [NCH-1:0] wr_sel;
  logic [NCH-1:0] rd_sel;
  logic [NCH-1:0] fl_sel;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;

  // Flags come only from the count registers so upstream back-pressure has no input-to-output path.
  always_comb begin
    EMP   = '0;
    FULL  = '0;
    AFULL = '0;
    for (int c = 0; c < NCH; c++) begin
      EMP[c]   = (cnt[c] == '0);
      FULL[c]  = (cnt[c] == CNT_FULL);
      AFULL[c] = (cnt[c] >= CNT_AF);
    end
  end

  assign CNT = cnt[CNT_IDX];

  // A flush on the same channel wins over both the write and the read.
  always_comb begin
    flush_enq = FLUSH && (FLUSH_IDX == ENQ_IDX);
    flush_deq = FLUSH && (FLUSH_IDX == DEQ_IDX);
    rd_ok     = DEQ && !EMP[DEQ_IDX] && !flush_deq;
    wr_rescue = rd_ok && (DEQ_IDX == ENQ_IDX);
    wr_ok     = ENQ && !flush_enq && (!FULL[ENQ_IDX] || wr_rescue);
    wr_addr   = {ENQ_IDX, tail[ENQ_IDX]};
    rd_addr   = {DEQ_IDX, head[DEQ_IDX]};
    wr_sel    = wr_ok ? (NCH'(1) << ENQ_IDX) : '0;
    rd_sel    = rd_ok ? (NCH'(1) << DEQ_IDX) : '0;
    fl_sel    = FLUSH ? (NCH'(1) << FLUSH_IDX) : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < NCH; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (fl_sel[c]) begin
          head[c] <= '0;
          tail[c] <= '0;
          cnt[c]  <= '0;
        end else begin
          if (wr_sel[c]) tail[c] <= tail[c] + 1'b1;
          if (rd_sel[c]) head[c] <= head[c] + 1'b1;
          if (wr_sel[c] && !rd_sel[c])
            cnt[c] <= cnt[c] + 1'b1;
          else if (rd_sel[c] && !wr_sel[c])
            cnt[c] <= cnt[c] - 1'b1;
        end
      end
    end
  end

  // When a full channel is read and written together, head==tail, so the read sees the old word.
  always_ff @(posedge CLK) begin
    if (wr_ok) ram[wr_addr] <= DIN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOT     <= '0;
      DOT_VLD <= 1'b0;
      DOT_IDX <= '0;
    end else if (rd_ok) begin
      DOT     <= ram[rd_addr];
      DOT_VLD <= 1'b1;
      DOT_IDX <= DEQ_IDX;
    end else begin
      DOT_VLD <= 1'b0;
    end
  end

`ifdef MCF_ERR_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR <= '0;
    end else begin
      if (ENQ && !flush_enq && FULL[ENQ_IDX] && !wr_rescue) ERR[0] <= 1'b1;
      if (DEQ && !flush_deq && EMP[DEQ_IDX])                ERR[1] <= 1'b1;
    end
  end
`endif

endmodule
